// File: rtl/game_round_timer_pkg.sv
// Shared definitions for the round timer: state encoding and duration width.
package game_round_timer_pkg;

    // Same 2-bit encoding the game FSM and counter renderer decode.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2,
        StExpired = 2'd3
    } timer_state_e;

    localparam int unsigned DurW                = 7;
    localparam int unsigned DefaultStartSeconds = 99;

endpackage

// File: rtl/game_round_timer_tick_divider.sv
// Prescaler dividing the system clock down to one tick per CLK_HZ enabled cycles.
module game_round_timer_tick_divider #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Terminal count reached; the parent only acts on it in cycles where it enables counting.
    assign tick_o = (cnt_q == TermCnt);

    // Next prescaler value: clear wins, wrap at terminal count, hold when not enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_round_timer.sv
// Round countdown timer: counts seconds from START_SECONDS to 0 with pause/resume.
module game_round_timer
    import game_round_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned START_SECONDS = DefaultStartSeconds,
    parameter int unsigned WARN_SECONDS  = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            pause_i,
    input  logic            resume_i,
    output logic [DurW-1:0] game_duration_o,
    output logic            second_tick_o,
    output logic            time_up_o,
    output logic            expired_o,
    output logic            running_o,
    output logic            warn_o
);

    localparam logic [DurW-1:0] StartVal = DurW'(START_SECONDS);
    localparam logic [DurW-1:0] WarnVal  = DurW'(WARN_SECONDS);

    timer_state_e    state_q, state_d;
    logic [DurW-1:0] dur_q, dur_d;
    logic            tick_q, tick_d;
    logic            time_up_q, time_up_d;
    logic            running_q, running_d;
    logic            expired_q, expired_d;
    logic            warn_q, warn_d;

    logic div_clear, div_enable, div_tick;
    logic pause_req, resume_req;

    // pause and resume in the same cycle cancel each other.
    assign pause_req  = pause_i & ~resume_i;
    assign resume_req = resume_i & ~pause_i;

    game_round_timer_tick_divider #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_divider (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (div_clear),
        .enable_i(div_enable),
        .tick_o  (div_tick)
    );

    // Next state, duration and output pulses; start beats pause/resume beats tick.
    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        tick_d     = 1'b0;
        time_up_d  = 1'b0;
        div_clear  = 1'b0;
        div_enable = 1'b0;
        if (start_i) begin
            state_d   = StRunning;
            dur_d     = StartVal;
            div_clear = 1'b1;
        end else begin
            unique case (state_q)
                StRunning: begin
                    if (pause_req) begin
                        // Prescaler holds, so a swallowed tick fires right after resume.
                        state_d = StPaused;
                    end else begin
                        div_enable = 1'b1;
                        if (div_tick && (dur_q != '0)) begin
                            dur_d  = dur_q - 1'b1;
                            tick_d = 1'b1;
                            if (dur_q == DurW'(1)) begin
                                state_d   = StExpired;
                                time_up_d = 1'b1;
                            end
                        end
                    end
                end
                StPaused: begin
                    if (resume_req) begin
                        state_d = StRunning;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == StRunning);
        expired_d = (state_d == StExpired);
        warn_d    = running_d && (dur_d <= WarnVal);
    end

    // State, duration and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            dur_q     <= StartVal;
            tick_q    <= 1'b0;
            time_up_q <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            warn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            tick_q    <= tick_d;
            time_up_q <= time_up_d;
            running_q <= running_d;
            expired_q <= expired_d;
            warn_q    <= warn_d;
        end
    end

    assign game_duration_o = dur_q;
    assign second_tick_o   = tick_q;
    assign time_up_o       = time_up_q;
    assign expired_o       = expired_q;
    assign running_o       = running_q;
    assign warn_o          = warn_q;

endmodule

// File: tb/tb_game_round_timer.sv
// Self-checking bench: directed scenarios plus random pulses against a seconds/phase model.
module tb_game_round_timer;

    localparam int unsigned Hz    = 10;
    localparam int unsigned Start = 3;
    localparam int unsigned Warn  = 2;

    logic       clk;
    logic       rst, start, pause, resume;
    logic [6:0] game_duration;
    logic       second_tick, time_up, expired, running, warn;

    game_round_timer #(
        .CLK_HZ       (Hz),
        .START_SECONDS(Start),
        .WARN_SECONDS (Warn)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .pause_i        (pause),
        .resume_i       (resume),
        .game_duration_o(game_duration),
        .second_tick_o  (second_tick),
        .time_up_o      (time_up),
        .expired_o      (expired),
        .running_o      (running),
        .warn_o         (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 idle, 1 counting, 2 frozen, 3 time over.
    int m_mode    = 0;
    int m_secs    = Start;
    int m_elapsed = 0;   // cycles already counted toward the current second
    bit m_tick    = 0;
    bit m_up      = 0;
    int m_tu_seen = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit s, input bit p, input bit res);
        m_tick = 0;
        m_up   = 0;
        if (r) begin
            m_mode = 0; m_secs = Start; m_elapsed = 0;
        end else if (s) begin
            m_mode = 1; m_secs = Start; m_elapsed = 0;
        end else if (m_mode == 1 && p && !res) begin
            m_mode = 2;
        end else if (m_mode == 2 && res && !p) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_elapsed++;
            if (m_elapsed == Hz) begin
                m_elapsed = 0;
                m_secs--;
                m_tick = 1;
                if (m_secs == 0) begin
                    m_mode = 3;
                    m_up   = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("duration", int'(game_duration), m_secs);
        check("second_tick", int'(second_tick), int'(m_tick));
        check("time_up", int'(time_up), int'(m_up));
        check("running", int'(running), int'(m_mode == 1));
        check("expired", int'(expired), int'(m_mode == 3));
        check("warn", int'(warn), int'(m_mode == 1 && m_secs <= Warn));
        if (time_up) m_tu_seen++;
    endtask

    // One clock: drive inputs at the falling edge, advance model at the rising edge, compare after.
    task automatic cyc(input bit r, input bit s, input bit p, input bit res);
        rst = r; start = s; pause = p; resume = res;
        @(posedge clk);
        model_step(r, s, p, res);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; resume = 1'b0;
        @(negedge clk);

        // Reset and quiet idle.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        idle(50);

        // Full countdown to expiry; exactly one time_up pulse.
        m_tu_seen = 0;
        cyc(0, 1, 0, 0);
        idle(9);
        check("first_dec_pending", int'(game_duration), 3);
        idle(1);
        check("first_dec_at_10", int'(game_duration), 2);
        idle(30);
        check("time_up_count", m_tu_seen, 1);
        check("expired_hold", int'(expired), 1);

        // Pause mid-second for 40 cycles, then resume.
        cyc(0, 1, 0, 0);
        idle(14);
        cyc(0, 0, 1, 0);
        idle(40);
        check("paused_dur", int'(game_duration), 2);
        cyc(0, 0, 0, 1);
        idle(25);

        // Pause on the tick edge swallows the decrement until after resume.
        cyc(0, 1, 0, 0);
        idle(9);
        cyc(0, 0, 1, 0);
        check("tick_swallowed", int'(game_duration), 3);
        idle(5);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check("tick_after_resume", int'(second_tick), 1);
        idle(5);

        // Restart while counting at 1: reload, no time_up.
        m_tu_seen = 0;
        cyc(0, 1, 0, 0);
        idle(25);
        check("at_one", int'(game_duration), 1);
        cyc(0, 1, 0, 0);
        check("reloaded", int'(game_duration), 3);
        idle(9);
        check("no_time_up", m_tu_seen, 0);
        idle(3);

        // Reset beats start in the same cycle, then a normal run.
        cyc(0, 1, 0, 0);
        idle(12);
        cyc(1, 1, 0, 0);
        check("rst_wins", int'(running), 0);
        idle(5);
        cyc(0, 1, 0, 0);
        idle(35);

        // Random pulses.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
